vexriscv_dbus_responder: RTL and testbench

- Bounded-latency formal bus responder for the VexRiscv simple dBus.
- Sits directly downstream of the core's dBus master port inside the riscv-formal wrapper.
- Converts free solver-driven inputs (rand_*) into a protocol-legal, fair slave: stall and response latency are hard-bounded by construction.
- Tracks outstanding reads in order, exposes the read address to memory checkers, and flags master-side handshake stability violations.

---
 rtl/vexriscv_dbus_responder_pkg.sv | 34 +++
 rtl/vexriscv_dbus_responder_fifo.sv | 61 ++++++
 rtl/vexriscv_dbus_responder.sv | 128 ++++++++++++
 tb/tb_vexriscv_dbus_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vexriscv_dbus_responder_pkg.sv
// Shared dBus types for the VexRiscv formal bus responder and its pending-read FIFO.
package vexriscv_bus_pkg;

   localparam int DBUS_AW = 32;
   localparam int DBUS_DW = 32;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } dbus_size_e;

   typedef struct packed {
      logic               wr;
      logic [DBUS_AW-1:0] address;
      logic [DBUS_DW-1:0] data;
      dbus_size_e         size;
   } dbus_cmd_t;

   function automatic dbus_cmd_t packCmd(
      input logic               wr,
      input logic [DBUS_AW-1:0] address,
      input logic [DBUS_DW-1:0] data,
      input logic [1:0]         size
   );
      dbus_cmd_t cmd;
      cmd.wr      = wr;
      cmd.address = address;
      cmd.data    = data;
      cmd.size    = dbus_size_e'(size);
      return cmd;
   endfunction

endpackage

// File: rtl/vexriscv_dbus_responder_fifo.sv
// In-order queue of outstanding read addresses; pointers wrap modulo DEPTH, occupancy kept separately.
module rvfi_pending_fifo
   import vexriscv_bus_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter int  WIDTH = DBUS_AW,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] headData,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             doPush;
   logic             doPop;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign doPush   = push && !full;
   assign doPop    = pop && !empty;
   assign headData = mem[rdPtr];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= nextPtr(wrPtr);
         if (doPop)  rdPtr <= nextPtr(rdPtr);
         case ({doPush, doPop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/vexriscv_dbus_responder.sv
// Formal dBus slave: turns free solver inputs into a fair responder with hard-bounded
// command stall and read latency, and flags unstable master handshakes.
module vexriscv_dbus_responder
   import vexriscv_bus_pkg::*;
#(
   parameter int  DEPTH         = 2,
   parameter int  MAX_CMD_STALL = 3,
   parameter int  MAX_RSP_LAT   = 3,
   parameter bit  ALLOW_ERROR   = 1'b0,
   localparam int CNT_W         = $clog2(DEPTH + 1)
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               dbus_cmd_valid,
   input  logic               dbus_cmd_wr,
   input  logic [DBUS_AW-1:0] dbus_cmd_address,
   input  logic [DBUS_DW-1:0] dbus_cmd_data,
   input  logic [1:0]         dbus_cmd_size,
   output logic               dbus_cmd_ready,
   output logic               dbus_rsp_valid,
   output logic [DBUS_DW-1:0] dbus_rsp_data,
   output logic               dbus_rsp_error,
   output logic [DBUS_AW-1:0] rsp_address,
   input  logic               rand_cmd_ready,
   input  logic               rand_rsp_valid,
   input  logic [DBUS_DW-1:0] rand_rsp_data,
   input  logic               rand_rsp_error,
   output logic [CNT_W-1:0]   pending_count,
   output logic               proto_err
);

   localparam int STALL_W = (MAX_CMD_STALL > 0) ? $clog2(MAX_CMD_STALL + 1) : 1;
   localparam int WAIT_W  = (MAX_RSP_LAT > 0) ? $clog2(MAX_RSP_LAT + 1) : 1;
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_CMD_STALL);
   localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(MAX_RSP_LAT);

   logic [STALL_W-1:0] stallCnt;
   logic [WAIT_W-1:0]  waitCnt;
   logic               full;
   logic               empty;
   logic [DBUS_AW-1:0] headAddr;
   logic               cmdReady;
   logic               rspValid;
   logic               accept;
   logic               pushRead;
   dbus_cmd_t          cmdNow;
   dbus_cmd_t          holdCmd_p1;
   logic               vld_p1;

   function automatic logic [STALL_W-1:0] satIncStall(input logic [STALL_W-1:0] v);
      return (v >= STALL_MAX) ? STALL_MAX : v + STALL_W'(1);
   endfunction

   function automatic logic [WAIT_W-1:0] satIncWait(input logic [WAIT_W-1:0] v);
      return (v >= WAIT_MAX) ? WAIT_MAX : v + WAIT_W'(1);
   endfunction

   rvfi_pending_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DBUS_AW)
   ) u_pending (
      .clock    (clock),
      .resetn   (resetn),
      .push     (pushRead),
      .pushData (dbus_cmd_address),
      .pop      (rspValid),
      .headData (headAddr),
      .full     (full),
      .empty    (empty),
      .count    (pending_count)
   );

   // Saturated counters force the handshake, so latency stays bounded whatever the solver picks.
   always_comb begin
      cmdReady = 1'b0;
      rspValid = 1'b0;
      if (resetn) begin
         cmdReady = !full && (rand_cmd_ready || (stallCnt == STALL_MAX));
         rspValid = !empty && (rand_rsp_valid || (waitCnt == WAIT_MAX));
      end
   end

   assign accept         = dbus_cmd_valid && cmdReady;
   assign pushRead       = accept && !dbus_cmd_wr;
   assign dbus_cmd_ready = cmdReady;
   assign dbus_rsp_valid = rspValid;
   assign dbus_rsp_data  = rspValid ? rand_rsp_data : '0;
   assign dbus_rsp_error = ALLOW_ERROR && rspValid && rand_rsp_error;
   assign rsp_address    = rspValid ? headAddr : '0;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         stallCnt <= '0;
      end else if (accept || !dbus_cmd_valid) begin
         stallCnt <= '0;
      end else if (!full) begin
         stallCnt <= satIncStall(stallCnt);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         waitCnt <= '0;
      end else if (rspValid || empty) begin
         waitCnt <= '0;
      end else begin
         waitCnt <= satIncWait(waitCnt);
      end
   end

   assign cmdNow = packCmd(dbus_cmd_wr, dbus_cmd_address, dbus_cmd_data, dbus_cmd_size);

   // p1: command held while refused, compared against what the master presents next cycle
   always_ff @(posedge clock) begin
      if (!resetn) begin
         vld_p1    <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         vld_p1 <= dbus_cmd_valid && !cmdReady;
         if (vld_p1 && (!dbus_cmd_valid || (cmdNow != holdCmd_p1))) proto_err <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (dbus_cmd_valid && !cmdReady) holdCmd_p1 <= cmdNow;
   end

endmodule

// File: tb/tb_vexriscv_dbus_responder.sv
// Table-driven bench for the dBus responder with an in-order read-address scoreboard.
module tb_vexriscv_dbus_responder;

   logic        clock = 1'b0;
   logic        resetn;
   logic        dbus_cmd_valid;
   logic        dbus_cmd_wr;
   logic [31:0] dbus_cmd_address;
   logic [31:0] dbus_cmd_data;
   logic [1:0]  dbus_cmd_size;
   logic        rand_cmd_ready;
   logic        rand_rsp_valid;
   logic [31:0] rand_rsp_data;
   logic        rand_rsp_error;

   logic        rdy0, rv0, err0, proto0;
   logic [31:0] data0, addr0;
   logic [1:0]  pend0;
   logic        rdy1, rv1, err1, proto1;
   logic [31:0] data1, addr1;
   logic [1:0]  pend1;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] expQ[$];

   typedef struct {
      logic        valid;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic        cmdRdy;
      logic        rspVld;
      logic        rspErr;
      logic        expReady;
      logic        expRspValid;
      logic [1:0]  expPending;
      logic        expErr0;
      logic        expErr1;
   } vec_t;

   vec_t vecs[$];

   always #5 clock = ~clock;

   vexriscv_dbus_responder #(.DEPTH(2), .MAX_CMD_STALL(3), .MAX_RSP_LAT(3), .ALLOW_ERROR(1'b0)) dut0 (
      .clock(clock), .resetn(resetn),
      .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_wr(dbus_cmd_wr),
      .dbus_cmd_address(dbus_cmd_address), .dbus_cmd_data(dbus_cmd_data),
      .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_ready(rdy0),
      .dbus_rsp_valid(rv0), .dbus_rsp_data(data0), .dbus_rsp_error(err0),
      .rsp_address(addr0), .rand_cmd_ready(rand_cmd_ready),
      .rand_rsp_valid(rand_rsp_valid), .rand_rsp_data(rand_rsp_data),
      .rand_rsp_error(rand_rsp_error), .pending_count(pend0), .proto_err(proto0)
   );

   vexriscv_dbus_responder #(.DEPTH(2), .MAX_CMD_STALL(3), .MAX_RSP_LAT(3), .ALLOW_ERROR(1'b1)) dut1 (
      .clock(clock), .resetn(resetn),
      .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_wr(dbus_cmd_wr),
      .dbus_cmd_address(dbus_cmd_address), .dbus_cmd_data(dbus_cmd_data),
      .dbus_cmd_size(dbus_cmd_size), .dbus_cmd_ready(rdy1),
      .dbus_rsp_valid(rv1), .dbus_rsp_data(data1), .dbus_rsp_error(err1),
      .rsp_address(addr1), .rand_cmd_ready(rand_cmd_ready),
      .rand_rsp_valid(rand_rsp_valid), .rand_rsp_data(rand_rsp_data),
      .rand_rsp_error(rand_rsp_error), .pending_count(pend1), .proto_err(proto1)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic setIn(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic cr, input logic rv, input logic re);
      dbus_cmd_valid   = v;
      dbus_cmd_wr      = w;
      dbus_cmd_address = a;
      dbus_cmd_data    = d;
      dbus_cmd_size    = 2'd2;
      rand_cmd_ready   = cr;
      rand_rsp_valid   = rv;
      rand_rsp_error   = re;
      rand_rsp_data    = $urandom;
   endtask

   // Pop before push so a same-cycle response to a just-offered read is caught as unexpected.
   task automatic monitor();
      logic [31:0] e;
      if (!resetn) begin
         expQ.delete();
      end else begin
         if (rv0) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected: got rsp_valid=1 addr=0x%0h expected no pending read", addr0);
            end else begin
               e = expQ.pop_front();
               check("rsp_address order", addr0, e);
            end
            check("rsp_data", data0, rand_rsp_data);
         end else begin
            check("rsp_address idle", addr0, 32'h0);
            check("rsp_data idle", data0, 32'h0);
         end
         if (dbus_cmd_valid && rdy0 && !dbus_cmd_wr) expQ.push_back(dbus_cmd_address);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic cr, input logic rv, input logic re,
                               input logic eRdy, input logic eRv, input logic [1:0] ePend,
                               input logic eE0, input logic eE1);
      vec_t t;
      t.valid = v; t.wr = w; t.addr = a; t.data = d;
      t.cmdRdy = cr; t.rspVld = rv; t.rspErr = re;
      t.expReady = eRdy; t.expRspValid = eRv; t.expPending = ePend;
      t.expErr0 = eE0; t.expErr1 = eE1;
      return t;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected TB_RESULT before 100000");
      $fatal(1);
   end

   initial begin
      // Read 0x100 with no solver help: forced ready on 4th cycle, forced rsp on 4th pending cycle.
      for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 32'h100, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h100, 0, 0, 0, 0, 1, 0, 2'd0, 0, 0));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
      // Three reads against DEPTH=2: third waits, including the full-plus-pop cycle.
      vecs.push_back(mk(1, 0, 32'h10, 0, 1, 0, 0, 1, 0, 2'd0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h20, 0, 1, 0, 0, 1, 0, 2'd1, 0, 0));
      vecs.push_back(mk(1, 0, 32'h30, 0, 1, 0, 0, 0, 0, 2'd2, 0, 0));
      vecs.push_back(mk(1, 0, 32'h30, 0, 1, 1, 0, 0, 1, 2'd2, 0, 0));
      vecs.push_back(mk(1, 0, 32'h30, 0, 1, 1, 0, 1, 1, 2'd1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 2'd1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'd0, 0, 0));
      // Write: accepted at once, never answered.
      vecs.push_back(mk(1, 1, 32'h40, 32'hDEADBEEF, 1, 0, 0, 1, 0, 2'd0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 2'd0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 2'd0, 0, 0));
      // Push and pop together; error only visible on the rsp cycle and only with ALLOW_ERROR.
      vecs.push_back(mk(1, 0, 32'h200, 0, 1, 0, 1, 1, 0, 2'd0, 0, 0));
      vecs.push_back(mk(1, 0, 32'h204, 0, 1, 1, 1, 1, 1, 2'd1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1, 1, 2'd1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 2'd0, 0, 0));

      resetn = 1'b0;
      setIn(1, 0, 32'h80, 0, 1, 1, 1);
      @(negedge clock);
      #1;
      check("reset cmd_ready", 32'(rdy0), 32'h0);
      check("reset rsp_valid", 32'(rv0), 32'h0);
      check("reset rsp_data", data0, 32'h0);
      check("reset rsp_error", 32'(err1), 32'h0);
      check("reset pending_count", 32'(pend0), 32'h0);
      check("reset proto_err", 32'(proto0), 32'h0);
      @(negedge clock);
      resetn = 1'b1;
      setIn(0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);

      for (int i = 0; i < vecs.size(); i++) begin
         setIn(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].data,
               vecs[i].cmdRdy, vecs[i].rspVld, vecs[i].rspErr);
         #1;
         check($sformatf("v%0d cmd_ready", i), 32'(rdy0), 32'(vecs[i].expReady));
         check($sformatf("v%0d rsp_valid", i), 32'(rv0), 32'(vecs[i].expRspValid));
         check($sformatf("v%0d pending_count", i), 32'(pend0), 32'(vecs[i].expPending));
         check($sformatf("v%0d rsp_error noerr", i), 32'(err0), 32'(vecs[i].expErr0));
         check($sformatf("v%0d rsp_error allow", i), 32'(err1), 32'(vecs[i].expErr1));
         monitor();
         @(negedge clock);
      end

      // Master changes address while refused, then reset clears the sticky flag and pending read.
      setIn(1, 0, 32'h60, 0, 1, 0, 0);
      #1; check("proto push ready", 32'(rdy0), 32'h1); monitor(); @(negedge clock);
      setIn(1, 0, 32'h50, 0, 0, 0, 0);
      #1; check("proto hold ready", 32'(rdy0), 32'h0); check("proto before", 32'(proto0), 32'h0);
      monitor(); @(negedge clock);
      setIn(1, 0, 32'h54, 0, 0, 0, 0);
      #1; check("proto change cycle", 32'(proto0), 32'h0); check("proto change pend", 32'(pend0), 32'h1);
      monitor(); @(negedge clock);
      setIn(0, 0, 0, 0, 0, 0, 0);
      #1; check("proto set", 32'(proto0), 32'h1); check("proto set pend", 32'(pend0), 32'h1);
      check("proto set rsp_valid", 32'(rv0), 32'h0);
      monitor(); @(negedge clock);
      resetn = 1'b0;
      setIn(1, 0, 32'h70, 0, 1, 1, 1);
      #1; check("proto sticky", 32'(proto0), 32'h1); check("midreset rsp_valid", 32'(rv0), 32'h0);
      check("midreset cmd_ready", 32'(rdy0), 32'h0); check("midreset rsp_address", addr0, 32'h0);
      monitor(); @(negedge clock);
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         setIn(0, 0, 0, 0, 0, 1, 0);
         #1;
         check($sformatf("post reset proto_err %0d", k), 32'(proto0), 32'h0);
         check($sformatf("post reset pending %0d", k), 32'(pend0), 32'h0);
         check($sformatf("post reset rsp_valid %0d", k), 32'(rv0), 32'h0);
         monitor();
         @(negedge clock);
      end

      check("scoreboard drained", 32'(expQ.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
